pd_switch_sequencer: RTL

Per-domain power-switch sequencer driven by the wakeup counter's per-domain power requests (logic, L1, L2, uDMA).
- Turns a level power request into an ordered, acknowledged sequence: staged header-switch enables through the domain's switch ring, then clock enable, then isolation and reset release.
- Reverses that sequence on power-down.
- Reports completion back to the upstream power-down FSM through `done_o`.

---
 rtl/pd_switch_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pd_switch_sequencer.sv
// Power-switch sequencer for one domain: staged switch-ring enables, clock enable, then iso/reset release; reversed on power-down.
// Define PD_ACK_TIMEOUT_EN to bound each ack wait to ACK_TIMEOUT cycles and flag overruns on a sticky err_o.
module pd_switch_sequencer #(
    parameter int N_STAGES      = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_DLY       = 2,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                power_i,
    output logic [N_STAGES-1:0] pd_send_o,
    input  logic [N_STAGES-1:0] pd_ack_i,
    output logic                clk_en_o,
    output logic                iso_o,
    output logic                rstn_o,
    output logic                done_o,
    output logic                err_o
);
    localparam int MAX_A = (SETTLE_CYCLES > RST_DLY) ? SETTLE_CYCLES : RST_DLY;
    localparam int MAX_V = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CW    = $clog2(MAX_V + 1);
    localparam int IW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RST_LD    = CW'(RST_DLY - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_STAGES - 1);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_UP_SW  = 3'd1;
    localparam logic [2:0] S_UP_CLK = 3'd2;
    localparam logic [2:0] S_ON     = 3'd3;
    localparam logic [2:0] S_DN_ISO = 3'd4;
    localparam logic [2:0] S_DN_SW  = 3'd5;

    logic [2:0]          state_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q;
    logic                settle_q;
    logic [N_STAGES-1:0] send_q;
    logic                ack_bit;
    logic                ack_ok;
    logic                tmo_hit;

    // Only the active stage's ack matters; power-down waits for it to drop.
    always_comb begin
        ack_bit = pd_ack_i[idx_q];
        ack_ok  = (state_q == S_DN_SW) ? !ack_bit : ack_bit;
    end

`ifdef PD_ACK_TIMEOUT_EN
    localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT);
    logic err_q;

    assign tmo_hit = (cnt_q == TMO);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            err_q <= 1'b0;
        else if ((state_q == S_UP_SW || state_q == S_DN_SW) && !settle_q && !ack_ok && tmo_hit)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            settle_q <= 1'b0;
            send_q   <= '0;
        end else begin
            case (state_q)
                S_OFF: if (power_i) begin
                    state_q   <= S_UP_SW;
                    idx_q     <= '0;
                    cnt_q     <= '0;
                    settle_q  <= 1'b0;
                    send_q[0] <= 1'b1;
                end
                // Each stage: wait for ack (cnt counts wait cycles), then settle (cnt counts down).
                S_UP_SW, S_DN_SW: begin
                    if (!settle_q) begin
                        if (ack_ok || tmo_hit) begin
                            settle_q <= 1'b1;
                            cnt_q    <= SETTLE_LD;
                        end
`ifdef PD_ACK_TIMEOUT_EN
                        else
                            cnt_q <= cnt_q + CW'(1);
`endif
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        settle_q <= 1'b0;
                        cnt_q    <= '0;
                        if (state_q == S_UP_SW) begin
                            if (idx_q == LAST_IDX) begin
                                state_q <= S_UP_CLK;
                                cnt_q   <= RST_LD;
                            end else begin
                                idx_q                  <= idx_q + IW'(1);
                                send_q[idx_q + IW'(1)] <= 1'b1;
                            end
                        end else begin
                            if (idx_q == '0) begin
                                state_q <= S_OFF;
                            end else begin
                                idx_q                  <= idx_q - IW'(1);
                                send_q[idx_q - IW'(1)] <= 1'b0;
                            end
                        end
                    end
                end
                S_UP_CLK: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CW'(1);
                    else
                        state_q <= S_ON;
                end
                S_ON: if (!power_i)
                    state_q <= S_DN_ISO;
                S_DN_ISO: begin
                    state_q          <= S_DN_SW;
                    idx_q            <= LAST_IDX;
                    cnt_q            <= '0;
                    settle_q         <= 1'b0;
                    send_q[LAST_IDX] <= 1'b0;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign pd_send_o = send_q;
    assign clk_en_o  = (state_q == S_UP_CLK) || (state_q == S_ON) || (state_q == S_DN_ISO);
    assign iso_o     = (state_q != S_ON);
    assign rstn_o    = (state_q == S_ON);
    assign done_o    = ((state_q == S_OFF) && !power_i) || ((state_q == S_ON) && power_i);
endmodule
